mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_rr_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The FSM states, the one-hot grant codes, the abort read-data pattern and
// the default timeout length all live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CORE = 2'd1,
    GNT_EXT  = 2'd2
  } arb_state_t;

  localparam logic [1:0]  GRANT_NONE = 2'b00;
  localparam logic [1:0]  GRANT_CORE = 2'b01;
  localparam logic [1:0]  GRANT_EXT  = 2'b10;

  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker. A lone requester always wins. On a tie,
// round-robin mode grants whichever side did not win last time, and
// fixed-priority mode always grants the core.
module arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       i_core_valid,
  input  logic       i_ext_valid,
  input  logic       i_last_ext,   // 1 = ext held the previous grant
  output logic [1:0] o_grant
);

  // Resolve the one-hot winner for this cycle.
  always_comb begin
    o_grant = GRANT_NONE;
    if (i_core_valid && i_ext_valid) begin
      if ((ROUND_ROBIN != 0) && !i_last_ext) o_grant = GRANT_EXT;
      else                                   o_grant = GRANT_CORE;
    end else if (i_core_valid) begin
      o_grant = GRANT_CORE;
    end else if (i_ext_valid) begin
      o_grant = GRANT_EXT;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU core and a PCPI extension.
// A requester is captured in IDLE, and the request is presented on mem_* one
// cycle later. The request is held until mem_ready_i arrives.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When it is defined, a grant that
// waits TIMEOUT_CYCLES cycles is aborted with ERR_RDATA and a timeout_o pulse.
//
// Handshake: a requester holds *_valid_i with stable fields until it sees
// *_ready_o high. *_ready_o is a single-cycle completion strobe and
// *_rdata_o is valid only in that cycle. The arbiter always spends one IDLE
// cycle between grants, so the requester can drop valid in that cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          ROUND_ROBIN    = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_valid_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_wstrb_i,
  output logic        core_ready_o,
  output logic [31:0] core_rdata_o,
  input  logic        ext_valid_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_wdata_i,
  input  logic [3:0]  ext_wstrb_i,
  output logic        ext_ready_o,
  output logic [31:0] ext_rdata_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_t  r_state;
  arb_state_t  w_next;
  logic        r_last_ext;
  logic        r_mem_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  w_pick;
  logic        w_in_grant;
  logic        w_timeout;
  logic        w_finish;
  logic [31:0] w_resp_data;

  arb_rr_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .i_core_valid (core_valid_i),
    .i_ext_valid  (ext_valid_i),
    .i_last_ext   (r_last_ext),
    .o_grant      (w_pick)
  );

  assign w_in_grant = (r_state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count stalled grant cycles; the counter sits at zero while idle, so each new grant starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            r_cnt <= '0;
    else if (!w_in_grant)   r_cnt <= '0;
    else if (!mem_ready_i)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = w_in_grant && !mem_ready_i && (r_cnt == CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish = w_in_grant && (mem_ready_i || w_timeout);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state: grant from IDLE, and return to IDLE on completion or abort.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick == GRANT_CORE)     w_next = GNT_CORE;
        else if (w_pick == GRANT_EXT) w_next = GNT_EXT;
      end
      GNT_CORE, GNT_EXT: begin
        if (w_finish) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the winner's request and the last-grant pointer on grant entry; clear valid on exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem_valid <= 1'b0;
      r_last_ext  <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else if (!w_in_grant && (w_pick != GRANT_NONE)) begin
      r_mem_valid <= 1'b1;
      r_last_ext  <= (w_pick == GRANT_EXT);
      r_addr      <= w_pick[0] ? core_addr_i  : ext_addr_i;
      r_wdata     <= w_pick[0] ? core_wdata_i : ext_wdata_i;
      r_wstrb     <= w_pick[0] ? core_wstrb_i : ext_wstrb_i;
    end else if (w_finish) begin
      r_mem_valid <= 1'b0;
    end
  end

  assign w_resp_data = mem_ready_i ? mem_rdata_i : ERR_RDATA;

  // Route the completion strobe and data to the owner only, and show the owner on grant_o.
  always_comb begin
    core_ready_o = 1'b0;
    core_rdata_o = '0;
    ext_ready_o  = 1'b0;
    ext_rdata_o  = '0;
    grant_o      = GRANT_NONE;
    case (r_state)
      GNT_CORE: begin
        grant_o      = GRANT_CORE;
        core_ready_o = w_finish;
        core_rdata_o = w_finish ? w_resp_data : '0;
      end
      GNT_EXT: begin
        grant_o     = GRANT_EXT;
        ext_ready_o = w_finish;
        ext_rdata_o = w_finish ? w_resp_data : '0;
      end
      default: ;
    endcase
  end

  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;
  assign timeout_o   = w_timeout;

endmodule
